rx_sampler: RTL and testbench

Serial receive front end that sits directly upstream of the receive shift/control stage. It synchronises the asynchronous rxd line and oversamples it 16x using a programmable divisor. It detects and qualifies the start bit and samples each data bit at mid-bit. It emits per-bit strobes plus start/stop framing strobes for the downstream shift register, and assembles a parallel byte with a valid strobe.

---
 rtl/rx_sampler_if.sv | 68 ++++++
 rtl/rx_sampler.sv | 240 ++++++++++++++++++++++++
 tb/tb_rx_sampler.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/rx_sampler_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_sampler_if
// Description : Bundle between a serial line source / configuration owner and
//               the rx_sampler receive front end.
//               Optional feature macro: RX_PARITY_EN adds parity_odd and
//               parity_err.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   enable      receiver enable (low forces IDLE)
//   divisor     tick period minus one, in clk cycles
//   rxd         asynchronous serial line, idle high
//   rx_bit      most recently sampled data bit
//   bit_valid   one-clk strobe, rx_bit holds a new data bit
//   start       one-clk strobe, start bit confirmed
//   stop        one-clk strobe, valid stop bit sampled
//   frame_err   one-clk strobe, stop bit sampled low
//   rx_data     assembled byte, LSB received first
//   data_valid  one-clk strobe coincident with stop
//   busy        receiver not in IDLE
//   parity_odd  (RX_PARITY_EN) odd parity select
//   parity_err  (RX_PARITY_EN) one-clk strobe, parity mismatch
// Modports: master = line source / configuration, slave = rx_sampler.
// ============================================================================
interface rx_sampler_if #(
  parameter int DIV_WIDTH = 16,
  parameter int DATA_BITS = 8
);
  logic                 enable;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 rxd;
  logic                 rx_bit;
  logic                 bit_valid;
  logic                 start;
  logic                 stop;
  logic                 frame_err;
  logic [DATA_BITS-1:0] rx_data;
  logic                 data_valid;
  logic                 busy;
`ifdef RX_PARITY_EN
  logic                 parity_odd;
  logic                 parity_err;

  modport master (
    output enable, divisor, rxd, parity_odd,
    input  rx_bit, bit_valid, start, stop, frame_err, rx_data, data_valid,
           busy, parity_err
  );
  modport slave (
    input  enable, divisor, rxd, parity_odd,
    output rx_bit, bit_valid, start, stop, frame_err, rx_data, data_valid,
           busy, parity_err
  );
`else
  modport master (
    output enable, divisor, rxd,
    input  rx_bit, bit_valid, start, stop, frame_err, rx_data, data_valid,
           busy
  );
  modport slave (
    input  enable, divisor, rxd,
    output rx_bit, bit_valid, start, stop, frame_err, rx_data, data_valid,
           busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/rx_sampler.sv
`default_nettype none
// ============================================================================
// Module      : rx_sampler
// Description : Serial receive front end. Synchronises rxd, oversamples it
//               with a programmable tick divisor, qualifies the start bit,
//               samples data bits at mid-bit and emits per-bit and framing
//               strobes plus an assembled byte.
//               Optional feature macro: RX_PARITY_EN (adds a PARITY state,
//               parity_odd input and parity_err strobe on the interface).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    rx_sampler_if.slave (enable, divisor, rxd in; strobes, rx_bit,
//          rx_data, busy out)
// ============================================================================
module rx_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int DATA_BITS  = 8
) (
  input wire          clk,
  input wire          rst_n,
  rx_sampler_if.slave bus
);

  localparam int c_os_w = $clog2(OVERSAMPLE);
  localparam int c_bc_w = $clog2(DATA_BITS + 1);

  localparam logic [c_os_w-1:0] c_os_half = c_os_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_os_w-1:0] c_os_last = c_os_w'(OVERSAMPLE - 1);
  localparam logic [c_bc_w-1:0] c_bit_last = c_bc_w'(DATA_BITS - 1);

  localparam logic [2:0] c_idle       = 3'd0;
  localparam logic [2:0] c_start_chk  = 3'd1;
  localparam logic [2:0] c_data       = 3'd2;
  localparam logic [2:0] c_stop       = 3'd3;
  localparam logic [2:0] c_break_wait = 3'd4;
`ifdef RX_PARITY_EN
  localparam logic [2:0] c_parity     = 3'd5;
`endif

  logic                 r_sync1, r_sync2, r_hist;
  logic [2:0]           r_state, w_next_state;
  logic [DIV_WIDTH-1:0] r_tick_cnt;
  logic [c_os_w-1:0]    r_os_cnt;
  logic [c_bc_w-1:0]    r_bit_cnt;
  logic                 w_fall, w_tick, w_mid_start, w_bit_end;

  logic                 r_rx_bit, r_bit_valid, r_start, r_stop;
  logic                 r_frame_err, r_data_valid;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 w_bit_valid_nxt, w_start_nxt, w_stop_nxt;
  logic                 w_frame_err_nxt, w_data_valid_nxt;

`ifdef RX_PARITY_EN
  logic                 r_parity_err, w_parity_err_nxt, r_par_bad, w_par_exp;
`endif

  // Two-flop synchroniser plus a history flop for edge detection; all three
  // reset high so the idle line does not look like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 1'b1;
    end else begin
      r_sync1 <= bus.rxd;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_fall      = r_hist & ~r_sync2;
  assign w_tick      = (r_state != c_idle) && (r_tick_cnt == '0);
  assign w_mid_start = w_tick && (r_os_cnt == c_os_half);
  // The oversample counter wraps naturally, so every OVERSAMPLE-th tick
  // after the start-bit midpoint lands on the middle of the next bit.
  assign w_bit_end   = w_tick && (r_os_cnt == c_os_last);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_idle;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:       if (w_fall) w_next_state = c_start_chk;
      c_start_chk:  if (w_mid_start) w_next_state = r_sync2 ? c_idle : c_data;
      c_data: begin
        if (w_bit_end && (r_bit_cnt == c_bit_last)) begin
`ifdef RX_PARITY_EN
          w_next_state = c_parity;
`else
          w_next_state = c_stop;
`endif
        end
      end
`ifdef RX_PARITY_EN
      c_parity:     if (w_bit_end) w_next_state = c_stop;
`endif
      c_stop:       if (w_bit_end) w_next_state = r_sync2 ? c_idle : c_break_wait;
      c_break_wait: if (r_sync2) w_next_state = c_idle;
      default:      w_next_state = c_idle;
    endcase
    if (!bus.enable) w_next_state = c_idle;
  end

`ifdef RX_PARITY_EN
  // By the parity slot rx_data holds exactly this frame's data bits.
  assign w_par_exp = (^r_rx_data) ^ bus.parity_odd;
`endif

  always_comb begin
    w_start_nxt      = 1'b0;
    w_bit_valid_nxt  = 1'b0;
    w_stop_nxt       = 1'b0;
    w_frame_err_nxt  = 1'b0;
    w_data_valid_nxt = 1'b0;
`ifdef RX_PARITY_EN
    w_parity_err_nxt = 1'b0;
`endif
    if (bus.enable) begin
      case (r_state)
        c_start_chk: if (w_mid_start && !r_sync2) w_start_nxt = 1'b1;
        c_data:      if (w_bit_end) w_bit_valid_nxt = 1'b1;
`ifdef RX_PARITY_EN
        c_parity:    if (w_bit_end && (r_sync2 != w_par_exp)) w_parity_err_nxt = 1'b1;
`endif
        c_stop: begin
          if (w_bit_end) begin
            if (r_sync2) begin
              w_stop_nxt       = 1'b1;
`ifdef RX_PARITY_EN
              w_data_valid_nxt = ~r_par_bad;
`else
              w_data_valid_nxt = 1'b1;
`endif
            end else begin
              w_frame_err_nxt  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------ counters
  // Reloading on IDLE->START_CHK aligns the sampling phase to the edge; a
  // new divisor is only picked up at a reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (!bus.enable) begin
      r_tick_cnt <= '0;
    end else if (r_state == c_idle) begin
      r_tick_cnt <= w_fall ? bus.divisor : '0;
    end else if (r_tick_cnt == '0) begin
      r_tick_cnt <= bus.divisor;
    end else begin
      r_tick_cnt <= r_tick_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_os_cnt <= '0;
    end else if (!bus.enable || (r_state == c_idle) || (r_state == c_break_wait)) begin
      r_os_cnt <= '0;
    end else if ((r_state == c_start_chk) && w_mid_start) begin
      r_os_cnt <= '0;
    end else if (w_tick) begin
      r_os_cnt <= r_os_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
    end else if (!bus.enable || (r_state == c_idle)) begin
      r_bit_cnt <= '0;
    end else if ((r_state == c_data) && w_bit_end) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  // ------------------------------------------------------------ outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_bit     <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_start      <= 1'b0;
      r_stop       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_data_valid <= 1'b0;
      r_rx_data    <= '0;
    end else begin
      r_bit_valid  <= w_bit_valid_nxt;
      r_start      <= w_start_nxt;
      r_stop       <= w_stop_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_data_valid <= w_data_valid_nxt;
      if (w_bit_valid_nxt) begin
        r_rx_bit  <= r_sync2;
        // LSB arrives first, so shift in from the MSB side.
        r_rx_data <= {r_sync2, r_rx_data[DATA_BITS-1:1]};
      end
    end
  end

`ifdef RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
      r_par_bad    <= 1'b0;
    end else begin
      r_parity_err <= w_parity_err_nxt;
      if (!bus.enable || (r_state == c_idle)) r_par_bad <= 1'b0;
      else if (w_parity_err_nxt)              r_par_bad <= 1'b1;
    end
  end

  assign bus.parity_err = r_parity_err;
`endif

  assign bus.rx_bit     = r_rx_bit;
  assign bus.bit_valid  = r_bit_valid;
  assign bus.start      = r_start;
  assign bus.stop       = r_stop;
  assign bus.frame_err  = r_frame_err;
  assign bus.rx_data    = r_rx_data;
  assign bus.data_valid = r_data_valid;
  assign bus.busy       = (r_state != c_idle);

endmodule
`default_nettype wire

// File: tb/tb_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_sampler
// Description : Self-checking bench for rx_sampler. Expected bits and bytes
//               are queued as frames are driven and compared as the DUT
//               strobes them out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_sampler;

  localparam int BIT_CLK = 64;  // divisor 3 -> 4 clk/tick, 16 ticks/bit

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rx_sampler_if #(.DIV_WIDTH(16), .DATA_BITS(8)) bus ();

  rx_sampler #(
    .OVERSAMPLE(16),
    .DIV_WIDTH (16),
    .DATA_BITS (8)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int t_edge  = 0;
  int t_start = 0;
  int cnt_start = 0, cnt_stop = 0, cnt_ferr = 0, cnt_dv = 0, cnt_bv = 0, cnt_perr = 0;

  logic       exp_bits[$];
  logic [7:0] exp_data[$];

`ifdef RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard side: pop and compare whenever the DUT strobes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.start) begin
        cnt_start++;
        t_start = cyc;
      end
      if (bus.stop)      cnt_stop++;
      if (bus.frame_err) cnt_ferr++;
`ifdef RX_PARITY_EN
      if (bus.parity_err) cnt_perr++;
`else
      if (bus.stop || bus.data_valid) check("stop_dv_pair", bus.stop, bus.data_valid);
`endif
      if (bus.bit_valid) begin
        cnt_bv++;
        check("bit_expected", exp_bits.size() != 0, 1);
        if (exp_bits.size() != 0) check("rx_bit", bus.rx_bit, exp_bits.pop_front());
      end
      if (bus.data_valid) begin
        cnt_dv++;
        check("dv_expected", exp_data.size() != 0, 1);
        if (exp_data.size() != 0) check("rx_data", bus.rx_data, exp_data.pop_front());
      end
    end
  end

  // Caller is always positioned just after a negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic ok);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    if (ok) exp_data.push_back(b);
    t_edge  = cyc;
    bus.rxd = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
`ifdef RX_PARITY_EN
    bus.rxd = (^b) ^ bus.parity_odd ^ par_flip;
    repeat (BIT_CLK) @(negedge clk);
`endif
    bus.rxd = stop_bit;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s_bv, s_dv, s_ferr, s_stop, s_start, busy_cyc;
    bus.rxd     = 1'b1;
    bus.enable  = 1'b0;
    bus.divisor = 16'd3;
`ifdef RX_PARITY_EN
    bus.parity_odd = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_outs", {bus.start, bus.stop, bus.bit_valid, bus.data_valid,
                       bus.frame_err, bus.rx_bit}, 0);
    rst_n      = 1'b1;
    bus.enable = 1'b1;
    repeat (10) @(negedge clk);

    // Basic frame 0xA5
    s_bv = cnt_bv; s_dv = cnt_dv; s_ferr = cnt_ferr;
    send_frame(8'hA5, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("start_latency", ((t_start - t_edge) >= 33) && ((t_start - t_edge) <= 36), 1);
    check("a5_bit_count", cnt_bv - s_bv, 8);
    check("a5_dv_count", cnt_dv - s_dv, 1);
    check("a5_no_ferr", cnt_ferr - s_ferr, 0);
    check("a5_rx_data", bus.rx_data, 8'hA5);
    check("a5_busy_idle", bus.busy, 0);

    // 12-clk low glitch while idle
    s_start = cnt_start; busy_cyc = 0;
    bus.rxd = 1'b0;
    repeat (12) begin @(negedge clk); if (bus.busy) busy_cyc++; end
    bus.rxd = 1'b1;
    repeat (80) begin @(negedge clk); if (bus.busy) busy_cyc++; end
    check("glitch_no_start", cnt_start - s_start, 0);
    check("glitch_busy_len", (busy_cyc >= 30) && (busy_cyc <= 34), 1);
    check("glitch_idle", bus.busy, 0);

    // Frame error with break, then recovery
    s_dv = cnt_dv; s_ferr = cnt_ferr;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    check("brk_ferr_once", cnt_ferr - s_ferr, 1);
    check("brk_no_dv", cnt_dv - s_dv, 0);
    check("brk_busy", bus.busy, 1);
    bus.rxd = 1'b1;
    repeat (10) @(negedge clk);
    check("brk_released", bus.busy, 0);
    send_frame(8'h81, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("r81_rx_data", bus.rx_data, 8'h81);
    check("r81_dv_count", cnt_dv - s_dv, 1);

    // Back-to-back frames
    s_dv = cnt_dv;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_dv_count", cnt_dv - s_dv, 2);
    check("b2b_rx_data", bus.rx_data, 8'hFF);

    // Abort 0x5A with enable after 4 bits
    s_bv = cnt_bv; s_stop = cnt_stop; s_ferr = cnt_ferr;
    for (int i = 0; i < 4; i++) exp_bits.push_back(i[0]);  // 0x5A LSBs: 0,1,0,1
    bus.rxd = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rxd = i[0];
      repeat ((i == 3) ? 40 : BIT_CLK) @(negedge clk);
    end
    check("abort_bits", cnt_bv - s_bv, 4);
    bus.enable = 1'b0;
    bus.rxd    = 1'b1;
    @(negedge clk);
    check("abort_idle", bus.busy, 0);
    check("abort_rx_data", bus.rx_data, 8'hAF);
    repeat (100) @(negedge clk);
    bus.enable = 1'b1;
    repeat (400) @(negedge clk);
    check("abort_hold", bus.rx_data, 8'hAF);
    check("abort_no_stop", cnt_stop - s_stop, 0);
    check("abort_no_ferr", cnt_ferr - s_ferr, 0);
    check("abort_no_bits", cnt_bv - s_bv, 4);
    send_frame(8'h12, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("r12_rx_data", bus.rx_data, 8'h12);

    // Reset mid-DATA during 0x33
    s_bv = cnt_bv;
    exp_bits.push_back(1'b1); exp_bits.push_back(1'b1); exp_bits.push_back(1'b0);
    bus.rxd = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    bus.rxd = 1'b1; repeat (BIT_CLK) @(negedge clk);
    bus.rxd = 1'b1; repeat (BIT_CLK) @(negedge clk);
    bus.rxd = 1'b0; repeat (40) @(negedge clk);
    check("rstmid_bits", cnt_bv - s_bv, 3);
    check("rstmid_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_outs", {bus.busy, bus.start, bus.stop, bus.bit_valid,
                          bus.data_valid, bus.frame_err, bus.rx_bit}, 0);
    check("rstmid_rx_data", bus.rx_data, 0);
    bus.rxd = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h77, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("r77_rx_data", bus.rx_data, 8'h77);

`ifdef RX_PARITY_EN
    s_dv = cnt_dv;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("par_err_pulse", cnt_perr, 1);
    check("par_no_dv", cnt_dv - s_dv, 0);
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("par_ok_dv", cnt_dv - s_dv, 1);
    check("par_ok_no_err", cnt_perr, 1);
    check("par_rx_data", bus.rx_data, 8'h07);
`endif

    check("bits_drained", exp_bits.size(), 0);
    check("data_drained", exp_data.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
